// File: rtl/regbank_ctx_ctrl_if.sv
// Register-bank and memory access bundle for the context save/restore sequencer.
//   master: the sequencer (drives bank selects/write, memory address/data/requests)
//   slave : the bank/memory side (returns bank read data, memory read data, mem_ready)
//   rb_sr1/rb_rData1          bank read port 1 (read data combinational from rb_sr1)
//   rb_dr/rb_wrData/rb_write  bank write port
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata/mem_ready  memory request/handshake
interface regbank_ctx_ctrl_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned RW = 5
) ();
    logic [RW-1:0] rb_sr1;
    logic [DW-1:0] rb_rData1;
    logic [RW-1:0] rb_dr;
    logic [DW-1:0] rb_wrData;
    logic          rb_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output rb_sr1, rb_dr, rb_wrData, rb_write,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  rb_rData1, mem_rdata, mem_ready
    );

    modport slave (
        input  rb_sr1, rb_dr, rb_wrData, rb_write,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output rb_rData1, mem_rdata, mem_ready
    );
endinterface

// File: rtl/regbank_ctx_ctrl.sv
// Context save/restore sequencer for the register bank (R0-R15, SP, PC).
// Save walks idx 0..NREGS-1 copying bank[idx] to memory at base+4*idx; restore copies
// memory back into the bank. While busy the sequencer owns bank read port 1 and the
// write port.
// Ports:
//   clk, reset (async, active-low)
//   save_req, restore_req  start requests, sampled only when idle (save wins if both)
//   base_addr              save-area byte address, latched at start
//   busy, done             busy from the first cycle after start through the done cycle
//   chksum                 XOR of all transferred words (only with REGBANK_CTX_CHECKSUM_EN)
//   bus                    regbank_ctx_ctrl_if.master: bank and memory access
// Optional feature macro: REGBANK_CTX_CHECKSUM_EN
module regbank_ctx_ctrl #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned RW    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic [AW-1:0]     base_addr,
    output logic              busy,
    output logic              done,
`ifdef REGBANK_CTX_CHECKSUM_EN
    output logic [DW-1:0]     chksum,
`endif
    regbank_ctx_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StSaveRd, StSaveWr, StRstRq, StRstWb, StDone
    } state_e;

    localparam logic [RW-1:0] LastIdx = RW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [RW-1:0] idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] data_q, data_d;

    logic          busy_q, busy_d, done_q, done_d;
    logic [RW-1:0] rb_sr1_q, rb_sr1_d, rb_dr_q, rb_dr_d;
    logic [DW-1:0] rb_wrdata_q, rb_wrdata_d;
    logic          rb_write_q, rb_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
`ifdef REGBANK_CTX_CHECKSUM_EN
    logic [DW-1:0] chk_q, chk_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = data_q;
`ifdef REGBANK_CTX_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (save_req || restore_req) begin
                    state_d = save_req ? StSaveRd : StRstRq;
                    base_d  = base_addr;
                    idx_d   = '0;
`ifdef REGBANK_CTX_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            StSaveRd: begin
                // rb_sr1_q already selects idx_q, so rb_rData1 is bank[idx_q] here
                data_d  = bus.rb_rData1;
                state_d = StSaveWr;
            end
            StSaveWr: begin
                if (bus.mem_ready) begin
`ifdef REGBANK_CTX_CHECKSUM_EN
                    chk_d = chk_q ^ data_q;
`endif
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + RW'(1);
                        state_d = StSaveRd;
                    end
                end
            end
            StRstRq: begin
                if (bus.mem_ready) begin
                    data_d  = bus.mem_rdata;
                    state_d = StRstWb;
                end
            end
            StRstWb: begin
`ifdef REGBANK_CTX_CHECKSUM_EN
                chk_d = chk_q ^ data_q;
`endif
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + RW'(1);
                    state_d = StRstRq;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state and held
        // unchanged across mem_ready stalls.
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        rb_sr1_d    = (state_d == StSaveRd) ? idx_d : '0;
        mem_we_d    = (state_d == StSaveWr);
        mem_re_d    = (state_d == StRstRq);
        mem_addr_d  = (mem_we_d || mem_re_d) ? base_d + (AW'(idx_d) << 2) : '0;
        mem_wdata_d = mem_we_d ? data_d : '0;
        rb_write_d  = (state_d == StRstWb);
        rb_dr_d     = rb_write_d ? idx_d : '0;
        rb_wrdata_d = rb_write_d ? data_d : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            base_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rb_sr1_q    <= '0;
            rb_dr_q     <= '0;
            rb_wrdata_q <= '0;
            rb_write_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
`ifdef REGBANK_CTX_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rb_sr1_q    <= rb_sr1_d;
            rb_dr_q     <= rb_dr_d;
            rb_wrdata_q <= rb_wrdata_d;
            rb_write_q  <= rb_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
`ifdef REGBANK_CTX_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rb_sr1    = rb_sr1_q;
    assign bus.rb_dr     = rb_dr_q;
    assign bus.rb_wrData = rb_wrdata_q;
    assign bus.rb_write  = rb_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
`ifdef REGBANK_CTX_CHECKSUM_EN
    assign chksum        = chk_q;
`endif

endmodule

// File: tb/tb_regbank_ctx_ctrl.sv
// Self-checking bench for regbank_ctx_ctrl: table of save/restore scenarios plus
// hand-written reset, abort and request-collision sequences.
module tb_regbank_ctx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        save_req, restore_req;
    logic [31:0] base_addr;
    logic        busy, done;
`ifdef REGBANK_CTX_CHECKSUM_EN
    logic [31:0] chksum;
`endif

    always #5 clk = ~clk;

    regbank_ctx_ctrl_if #(.DW(32), .AW(32), .RW(5)) bus ();

    regbank_ctx_ctrl #(.NREGS(16), .DW(32), .AW(32), .RW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .save_req   (save_req),
        .restore_req(restore_req),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
`ifdef REGBANK_CTX_CHECKSUM_EN
        .chksum     (chksum),
`endif
        .bus        (bus)
    );

    // Bank and memory models
    logic [31:0] bank [0:31];
    logic [31:0] rd_base;
    int          stall;
    int          wait_cnt;
    int          load_mode;
    logic        clr_mon;

    assign bus.rb_rData1 = bank[bus.rb_sr1];
    assign bus.mem_ready = (bus.mem_we || bus.mem_re) && (wait_cnt >= stall);
    assign bus.mem_rdata = ((bus.mem_addr - rd_base) >> 2) * 32'h11;

    function automatic logic [31:0] save_pat(int i);
        return (i >= 1 && i <= 8) ? 32'(50000 * i) : 32'h0;
    endfunction

    // Monitor logs
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [31:0] acc_addr [0:63];
    logic [4:0]  wb_dr [0:63];
    logic [31:0] wb_data [0:63];
    int wr_cnt, wb_cnt, acc_cnt, re_cyc, done_cnt, v_both, v_wbre, v_addr;
    logic        prev_pending;
    logic [31:0] prev_addr;

    always @(posedge clk) begin
        if (load_mode == 1) begin
            for (int i = 0; i < 32; i++) bank[i] <= save_pat(i);
        end else if (load_mode == 2) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'h0;
        end else if (bus.rb_write) begin
            bank[bus.rb_dr] <= bus.rb_wrData;
        end

        if ((bus.mem_we || bus.mem_re) && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;

        if (clr_mon) begin
            wr_cnt <= 0; wb_cnt <= 0; acc_cnt <= 0; re_cyc <= 0; done_cnt <= 0;
            v_both <= 0; v_wbre <= 0; v_addr <= 0; prev_pending <= 1'b0;
            prev_addr <= '0;
        end else begin
            if (bus.mem_we && bus.mem_ready && wr_cnt < 64) begin
                wr_addr[wr_cnt] <= bus.mem_addr;
                wr_data[wr_cnt] <= bus.mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if ((bus.mem_we || bus.mem_re) && bus.mem_ready && acc_cnt < 64) begin
                acc_addr[acc_cnt] <= bus.mem_addr;
                acc_cnt <= acc_cnt + 1;
            end
            if (bus.rb_write && wb_cnt < 64) begin
                wb_dr[wb_cnt]   <= bus.rb_dr;
                wb_data[wb_cnt] <= bus.rb_wrData;
                wb_cnt <= wb_cnt + 1;
            end
            if (bus.mem_re) re_cyc <= re_cyc + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.mem_we && bus.mem_re) v_both <= v_both + 1;
            if (bus.rb_write && bus.mem_re) v_wbre <= v_wbre + 1;
            if (prev_pending && bus.mem_addr != prev_addr) v_addr <= v_addr + 1;
            prev_pending <= (bus.mem_we || bus.mem_re) && !bus.mem_ready;
            prev_addr    <= bus.mem_addr;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load_bank(input int mode);
        @(negedge clk); load_mode = mode;
        @(negedge clk); load_mode = 0;
    endtask

    task automatic clear_mon();
        @(negedge clk); clr_mon = 1'b1;
        @(negedge clk); clr_mon = 1'b0;
    endtask

    task automatic start_op(input logic sv, input logic rs, input logic [31:0] base);
        @(negedge clk);
        save_req = sv; restore_req = rs; base_addr = base;
        @(posedge clk);   // request-sampling edge (cycle 0)
        @(negedge clk);   // cycle 1
        save_req = 1'b0; restore_req = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", {31'b0, done}, 32'h1);
    endtask

    typedef struct {
        logic        sv;
        logic        rs;
        logic [31:0] base;
        int          stall;
        int          exp_wr;
        int          exp_wb;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_done_cyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          cyc;
        int          n;
        logic [31:0] x;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 0, 16, 0,  32'h0000_1000, 32'h0000_103C, 33};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 1, 16, 0,  32'h0000_0400, 32'h0000_043C, 49};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_2000, 3, 0,  16, 32'h0000_2000, 32'h0000_203C, 81};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1000, 0, 16, 0,  32'h0000_1000, 32'h0000_103C, 33};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 0, 16, 0,  32'hFFFF_FFF8, 32'h0000_0034, 33};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0100, 0, 0,  16, 32'h0000_0100, 32'h0000_013C, 33};

        reset = 1'b0; save_req = 1'b1; restore_req = 1'b0; base_addr = 32'h0;
        stall = 0; rd_base = 32'h0; load_mode = 0; clr_mon = 1'b0;

        // Reset held with save_req asserted
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_re", {31'b0, bus.mem_re}, 32'h0);
        chk("rst_rb_write", {31'b0, bus.rb_write}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        save_req = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_busy", {31'b0, busy}, 32'h0);
        chk("rel_mem_we", {31'b0, bus.mem_we}, 32'h0);

        // Table-driven scenarios
        for (int v = 0; v < 6; v++) begin
            stall   = vecs[v].stall;
            rd_base = vecs[v].base;
            load_bank(vecs[v].sv ? 1 : 2);
            clear_mon();
            start_op(vecs[v].sv, vecs[v].rs, vecs[v].base);
            chk($sformatf("v%0d_busy_c1", v), {31'b0, busy}, 32'h1);
            wait_done(cyc);
            chk($sformatf("v%0d_done_cycle", v), cyc, vecs[v].exp_done_cyc);
            chk($sformatf("v%0d_busy_at_done", v), {31'b0, busy}, 32'h1);
`ifdef REGBANK_CTX_CHECKSUM_EN
            x = 32'h0;
            for (int i = 0; i < 16; i++) x ^= vecs[v].sv ? save_pat(i) : 32'(i) * 32'h11;
            chk($sformatf("v%0d_chksum", v), chksum, x);
`endif
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_busy_after", v), {31'b0, busy}, 32'h0);
            chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            chk($sformatf("v%0d_wr_cnt", v), wr_cnt, vecs[v].exp_wr);
            chk($sformatf("v%0d_wb_cnt", v), wb_cnt, vecs[v].exp_wb);
            chk($sformatf("v%0d_re_cyc", v), re_cyc,
                vecs[v].exp_wb == 0 ? 0 : 16 * (vecs[v].stall + 1));
            chk($sformatf("v%0d_first_addr", v), acc_addr[0], vecs[v].exp_first);
            chk($sformatf("v%0d_last_addr", v), acc_addr[acc_cnt > 0 ? acc_cnt - 1 : 0],
                vecs[v].exp_last);
            chk($sformatf("v%0d_we_and_re", v), v_both, 0);
            chk($sformatf("v%0d_wb_during_re", v), v_wbre, 0);
            chk($sformatf("v%0d_addr_stall_stable", v), v_addr, 0);
            if (vecs[v].exp_wr > 0) begin
                for (int i = 0; i < 16; i++) begin
                    chk($sformatf("v%0d_wr_addr%0d", v, i), wr_addr[i],
                        vecs[v].base + 32'(4 * i));
                    chk($sformatf("v%0d_wr_data%0d", v, i), wr_data[i], save_pat(i));
                end
            end
            if (vecs[v].exp_wb > 0) begin
                for (int i = 0; i < 16; i++) begin
                    chk($sformatf("v%0d_wb_dr%0d", v, i), {27'b0, wb_dr[i]}, 32'(i));
                    chk($sformatf("v%0d_wb_data%0d", v, i), wb_data[i], 32'(i) * 32'h11);
                    chk($sformatf("v%0d_bank%0d", v, i), bank[i], 32'(i) * 32'h11);
                end
            end
        end

        // Reset mid-save after the idx 5 write completes
        stall = 0;
        load_bank(1);
        clear_mon();
        start_op(1'b1, 1'b0, 32'h0000_3000);
        n = 0;
        while (wr_cnt < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_wr_cnt", wr_cnt, 6);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("abort_mem_re", {31'b0, bus.mem_re}, 32'h0);
        chk("abort_rb_write", {31'b0, bus.rb_write}, 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        chk("abort_rb_sr1", {27'b0, bus.rb_sr1}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        clear_mon();
        start_op(1'b1, 1'b0, 32'h0000_3000);
        wait_done(cyc);
        chk("abort_restart_cycle", cyc, 33);
        chk("abort_restart_first", wr_addr[0], 32'h0000_3000);
        chk("abort_restart_data1", wr_data[1], 32'd50000);

        // restore_req pulsed mid-save is ignored
        load_bank(1);
        clear_mon();
        start_op(1'b1, 1'b0, 32'h0000_1000);
        repeat (9) @(negedge clk);
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        wait_done(cyc);
        repeat (40) @(negedge clk);
        chk("midreq_done_cnt", done_cnt, 1);
        chk("midreq_re_cyc", re_cyc, 0);
        chk("midreq_wr_cnt", wr_cnt, 16);
        chk("midreq_idle", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
